// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the SysID probe master.
package sysid_probe_pkg;

    localparam int unsigned TMR_W  = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ID_OFFSET = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] TS_OFFSET = 32'h0000_0004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_WT_ID,
        ST_RD_TS,
        ST_WT_TS,
        ST_FIN
    } state_e;

    // True while a bus transaction is outstanding.
    function automatic logic in_xfer(input state_e s);
        return (s == ST_RD_ID) || (s == ST_WT_ID) || (s == ST_RD_TS) || (s == ST_WT_TS);
    endfunction

endpackage

// File: rtl/sysid_probe_master_if.sv
// Avalon-MM read-only link between the probe master and the SysID slave.
interface sysid_probe_master_if;
    import sysid_probe_pkg::*;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );

endinterface

// File: rtl/sysid_probe_timer.sv
// Per-transaction watchdog: loads LIMIT, counts down while enabled, flags zero.
module sysid_probe_timer
    import sysid_probe_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TMR_W-1:0] LIMIT_W = TMR_W'(LIMIT);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             exp_q, exp_d;

    // Load wins over decrement; the counter parks at zero once expired.
    always_comb begin
        cnt_d = cnt_q;
        exp_d = exp_q;
        if (load_i) begin
            cnt_d = LIMIT_W;
            exp_d = (LIMIT_W == TMR_W'(0));
        end else if (en_i && (cnt_q != TMR_W'(0))) begin
            cnt_d = cnt_q - TMR_W'(1);
            exp_d = (cnt_q == TMR_W'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            exp_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            exp_q <= exp_d;
        end
    end

    assign expired_o = exp_q;

endmodule

// File: rtl/sysid_probe_master.sv
// Reads the SysID ID and timestamp words, compares them with build-time values
// and holds the verdict plus captured words until the next probe.
module sysid_probe_master
    import sysid_probe_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [DATA_W-1:0] EXPECTED_ID = 32'd0,
    parameter logic [DATA_W-1:0] EXPECTED_TS = 32'd1488294195,
    parameter bit                USE_RDV     = 1'b0,
    parameter int unsigned       TIMEOUT     = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              id_ok,
    output logic              ts_ok,
    output logic              timeout,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] ts_value,
    sysid_probe_master_if.master avm
);

    state_e            state_q, state_d;
    logic              read_q, read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              id_ok_q, id_ok_d;
    logic              ts_ok_q, ts_ok_d;
    logic              tmo_q, tmo_d;
    logic [DATA_W-1:0] id_val_q, id_val_d;
    logic [DATA_W-1:0] ts_val_q, ts_val_d;
    logic              tmr_load, tmr_en, tmr_expired;
    logic              cap;
    logic              accept_c;

    assign accept_c = read_q & ~avm.avm_waitrequest;

    sysid_probe_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .load_i    (tmr_load),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Next-state, bus request, capture and compare.
    always_comb begin
        state_d  = state_q;
        read_d   = read_q;
        addr_d   = addr_q;
        pass_d   = pass_q;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        tmo_d    = tmo_q;
        id_val_d = id_val_q;
        ts_val_d = ts_val_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        cap      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RD_ID;
                    read_d   = 1'b1;
                    addr_d   = BASE_ADDR + ID_OFFSET;
                    pass_d   = 1'b0;
                    id_ok_d  = 1'b0;
                    ts_ok_d  = 1'b0;
                    tmo_d    = 1'b0;
                    id_val_d = '0;
                    ts_val_d = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    tmo_d   = 1'b1;
                    read_d  = 1'b0;
                    state_d = ST_FIN;
                end else if (accept_c) begin
                    if (USE_RDV) begin
                        read_d  = 1'b0;
                        state_d = (state_q == ST_RD_ID) ? ST_WT_ID : ST_WT_TS;
                    end else begin
                        cap = 1'b1;
                    end
                end
            end
            ST_WT_ID, ST_WT_TS: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    tmo_d   = 1'b1;
                    state_d = ST_FIN;
                end else if (avm.avm_readdatavalid) begin
                    cap = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
            end
        endcase

        // Capture advances ID -> TS read, or TS -> FIN.
        if (cap) begin
            if ((state_q == ST_RD_ID) || (state_q == ST_WT_ID)) begin
                id_val_d = avm.avm_readdata;
                id_ok_d  = (avm.avm_readdata == EXPECTED_ID);
                state_d  = ST_RD_TS;
                read_d   = 1'b1;
                addr_d   = BASE_ADDR + TS_OFFSET;
                tmr_load = 1'b1;
            end else begin
                ts_val_d = avm.avm_readdata;
                ts_ok_d  = (avm.avm_readdata == EXPECTED_TS);
                state_d  = ST_FIN;
                read_d   = 1'b0;
            end
        end

        if (state_d == ST_FIN) begin
            pass_d = id_ok_d & ts_ok_d & ~tmo_d;
        end
        done_d = (state_d == ST_FIN);
        busy_d = in_xfer(state_d);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            read_q   <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            tmo_q    <= 1'b0;
            id_val_q <= '0;
            ts_val_q <= '0;
        end else begin
            state_q  <= state_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            tmo_q    <= tmo_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
        end
    end

    assign avm.avm_address = addr_q;
    assign avm.avm_read    = read_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout         = tmo_q;
    assign id_value        = id_val_q;
    assign ts_value        = ts_val_q;

endmodule

// File: tb/tb_sysid_probe_master.sv
// Bench: two probe masters (readdata-on-accept, readdatavalid with short timeout)
// against behavioural SysID slaves, with expected results kept in a scoreboard.
module tb_sysid_probe_master;
    import sysid_probe_pkg::*;

    localparam logic [31:0] EXP_TS = 32'd1488294195;
    localparam logic [31:0] BASE1  = 32'h0000_0100;
    localparam int          TMO1   = 16;

    typedef struct packed {
        logic [31:0] id_v;
        logic [31:0] ts_v;
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic        pass;
    } res_t;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic        rst_n0, rst_n1, start0, start1;
    logic        busy0, done0, pass0, id_ok0, ts_ok0, tmo0;
    logic        busy1, done1, pass1, id_ok1, ts_ok1, tmo1;
    logic [31:0] id_val0, ts_val0, id_val1, ts_val1;

    sysid_probe_master_if bus0();
    sysid_probe_master_if bus1();

    sysid_probe_master #(
        .BASE_ADDR(32'h0), .EXPECTED_ID(32'd0), .EXPECTED_TS(EXP_TS),
        .USE_RDV(1'b0), .TIMEOUT(255)
    ) u0 (
        .clock(clk), .reset_n(rst_n0), .start(start0), .busy(busy0), .done(done0),
        .pass(pass0), .id_ok(id_ok0), .ts_ok(ts_ok0), .timeout(tmo0),
        .id_value(id_val0), .ts_value(ts_val0), .avm(bus0.master)
    );

    sysid_probe_master #(
        .BASE_ADDR(BASE1), .EXPECTED_ID(32'd0), .EXPECTED_TS(EXP_TS),
        .USE_RDV(1'b1), .TIMEOUT(TMO1)
    ) u1 (
        .clock(clk), .reset_n(rst_n1), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .id_ok(id_ok1), .ts_ok(ts_ok1), .timeout(tmo1),
        .id_value(id_val1), .ts_value(ts_val1), .avm(bus1.master)
    );

    // Slave configuration, written only by the test sequence.
    int          ws0, ws1, rdv_lat;
    bit          stuck0, stuck1;
    logic [31:0] id_w0, ts_w0, id_w1, ts_w1;
    int          stray_req;

    // Slave-private state.
    int          wcnt0, wcnt1, pend1, stray_ack;
    logic [31:0] held1;

    // Slave 0: data on the accept cycle, ws0 stall cycles per read.
    always @(negedge clk) begin
        bus0.avm_readdatavalid = 1'b0;
        bus0.avm_readdata      = bus0.avm_address[2] ? ts_w0 : id_w0;
        if (bus0.avm_read && !stuck0 && wcnt0 >= ws0) begin
            bus0.avm_waitrequest = 1'b0;
            wcnt0 = 0;
        end else begin
            bus0.avm_waitrequest = stuck0 | bus0.avm_read;
            if (bus0.avm_read) wcnt0++; else wcnt0 = 0;
        end
    end

    // Slave 1: readdatavalid rdv_lat cycles after accept, optional stray pulse.
    always @(negedge clk) begin
        bus1.avm_readdatavalid = 1'b0;
        bus1.avm_readdata      = 32'hBAD0_BAD0;
        if (pend1 > 0) begin
            pend1--;
            if (pend1 == 0) begin
                bus1.avm_readdatavalid = 1'b1;
                bus1.avm_readdata      = held1;
            end
        end
        if (stray_req != stray_ack) begin
            bus1.avm_readdatavalid = 1'b1;
            bus1.avm_readdata      = 32'hFFFF_FFFF;
            stray_ack              = stray_req;
        end
        if (bus1.avm_read && !stuck1 && wcnt1 >= ws1) begin
            bus1.avm_waitrequest = 1'b0;
            wcnt1 = 0;
        end else begin
            bus1.avm_waitrequest = stuck1 | bus1.avm_read;
            if (bus1.avm_read) wcnt1++; else wcnt1 = 0;
        end
        if (bus1.avm_read && !bus1.avm_waitrequest) begin
            pend1 = rdv_lat;
            held1 = bus1.avm_address[2] ? ts_w1 : id_w1;
        end
    end

    int          n_checks, n_pass;
    res_t        sb[$];
    logic [31:0] acc_q[$];
    bit          r_got, r_stable, r_drop, r_busy1, r_busy_done, r_rd_done;
    int          r_lat;

    function automatic res_t mk_res(input logic [31:0] iv, input logic [31:0] tv,
                                    input logic io, input logic to, input logic tm,
                                    input logic ps);
        res_t r;
        r.id_v = iv; r.ts_v = tv; r.id_ok = io; r.ts_ok = to; r.tmo = tm; r.pass = ps;
        return r;
    endfunction

    function automatic res_t obs(input int w);
        if (w == 0) return mk_res(id_val0, ts_val0, id_ok0, ts_ok0, tmo0, pass0);
        return mk_res(id_val1, ts_val1, id_ok1, ts_ok1, tmo1, pass1);
    endfunction

    function automatic logic [102:0] all_outs(input int w);
        if (w == 0)
            return {busy0, done0, pass0, id_ok0, ts_ok0, tmo0, id_val0, ts_val0,
                    bus0.avm_address, bus0.avm_read};
        return {busy1, done1, pass1, id_ok1, ts_ok1, tmo1, id_val1, ts_val1,
                bus1.avm_address, bus1.avm_read};
    endfunction

    // Pulse start, then watch the bus cycle by cycle until done or budget runs out.
    task automatic run_probe(input int w, input int budget);
        logic        rd, wr, dn, prd, pwr, pacc;
        logic [31:0] ad, pad;
        @(negedge clk);
        if (w == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        r_got = 0; r_lat = 0; r_stable = 1; r_drop = 1;
        r_busy1 = 0; r_busy_done = 1; r_rd_done = 1;
        acc_q.delete();
        prd = 0; pwr = 0; pacc = 0; pad = '0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk); #1;
            if (n == 1) begin start0 = 1'b0; start1 = 1'b0; end
            rd = (w == 0) ? bus0.avm_read : bus1.avm_read;
            wr = (w == 0) ? bus0.avm_waitrequest : bus1.avm_waitrequest;
            ad = (w == 0) ? bus0.avm_address : bus1.avm_address;
            dn = (w == 0) ? done0 : done1;
            if (n == 1) r_busy1 = (w == 0) ? busy0 : busy1;
            if (prd && pwr && !dn && (!rd || ad !== pad)) r_stable = 0;
            if (w == 1 && pacc && rd) r_drop = 0;
            if (rd && !wr) acc_q.push_back(ad);
            prd = rd; pwr = wr; pad = ad; pacc = rd && !wr;
            if (dn) begin
                r_got = 1; r_lat = n; r_rd_done = rd;
                r_busy_done = (w == 0) ? busy0 : busy1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (all_outs(0) !== 103'd0) $display("FAIL reset_u0: got %h want 0", all_outs(0));
        else n_pass++;
        n_checks++;
        if (all_outs(1) !== 103'd0) $display("FAIL reset_u1: got %h want 0", all_outs(1));
        else n_pass++;
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({busy0, done0, bus0.avm_read} !== 3'b000)
            $display("FAIL idle_u0: got %b want 000", {busy0, done0, bus0.avm_read});
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        res_t e;
        ws0 = 0; stuck0 = 0; id_w0 = 32'd0; ts_w0 = EXP_TS;
        sb.push_back(mk_res(32'd0, EXP_TS, 1'b1, 1'b1, 1'b0, 1'b1));
        run_probe(0, 50);
        e = sb.pop_front();
        n_checks++;
        if (r_got !== 1'b1 || r_lat != 3) $display("FAIL zw_latency: got done=%0b at %0d want 1 at 3", r_got, r_lat);
        else n_pass++;
        n_checks++;
        if (obs(0) !== e) $display("FAIL zw_results: got %h want %h", obs(0), e);
        else n_pass++;
        n_checks++;
        if (!(acc_q.size() == 2 && acc_q[0] === 32'h0 && acc_q[1] === 32'h4))
            $display("FAIL zw_addrs: got %0d accepts want 0x0,0x4", acc_q.size());
        else n_pass++;
        n_checks++;
        if ({r_busy1, r_busy_done, r_rd_done} !== 3'b100)
            $display("FAIL zw_busy: got busy1/busy_done/read_done=%b want 100", {r_busy1, r_busy_done, r_rd_done});
        else n_pass++;
    endtask

    task automatic test_bad_id();
        res_t e;
        ws0 = 0; id_w0 = 32'h0000_0001; ts_w0 = EXP_TS;
        sb.push_back(mk_res(32'h1, EXP_TS, 1'b0, 1'b1, 1'b0, 1'b0));
        run_probe(0, 50);
        e = sb.pop_front();
        n_checks++;
        if (r_got !== 1'b1 || r_lat != 3) $display("FAIL badid_latency: got done=%0b at %0d want 1 at 3", r_got, r_lat);
        else n_pass++;
        n_checks++;
        if (obs(0) !== e) $display("FAIL badid_results: got %h want %h", obs(0), e);
        else n_pass++;
    endtask

    task automatic test_waitrequest();
        res_t e;
        ws0 = 4; id_w0 = 32'd0; ts_w0 = EXP_TS;
        sb.push_back(mk_res(32'd0, EXP_TS, 1'b1, 1'b1, 1'b0, 1'b1));
        run_probe(0, 80);
        e = sb.pop_front();
        n_checks++;
        if (r_got !== 1'b1 || r_lat != 11) $display("FAIL wr_latency: got done=%0b at %0d want 1 at 11", r_got, r_lat);
        else n_pass++;
        n_checks++;
        if (r_stable !== 1'b1) $display("FAIL wr_stable: got %0b want 1", r_stable);
        else n_pass++;
        n_checks++;
        if (obs(0) !== e) $display("FAIL wr_results: got %h want %h", obs(0), e);
        else n_pass++;
        n_checks++;
        if (!(acc_q.size() == 2 && acc_q[0] === 32'h0 && acc_q[1] === 32'h4))
            $display("FAIL wr_addrs: got %0d accepts want 0x0,0x4", acc_q.size());
        else n_pass++;
        ws0 = 0;
    endtask

    task automatic test_rdv();
        res_t e;
        ws1 = 0; stuck1 = 0; rdv_lat = 2; id_w1 = 32'd0; ts_w1 = EXP_TS;
        sb.push_back(mk_res(32'd0, EXP_TS, 1'b1, 1'b1, 1'b0, 1'b1));
        run_probe(1, 80);
        e = sb.pop_front();
        n_checks++;
        if (r_got !== 1'b1) $display("FAIL rdv_done: got %0b want 1", r_got);
        else n_pass++;
        n_checks++;
        if (r_drop !== 1'b1) $display("FAIL rdv_read_drop: got %0b want 1", r_drop);
        else n_pass++;
        n_checks++;
        if (obs(1) !== e) $display("FAIL rdv_results: got %h want %h", obs(1), e);
        else n_pass++;
        n_checks++;
        if (!(acc_q.size() == 2 && acc_q[0] === BASE1 && acc_q[1] === BASE1 + 32'h4))
            $display("FAIL rdv_addrs: got %0d accepts want 0x100,0x104", acc_q.size());
        else n_pass++;
        // A readdatavalid while idle must leave the held results alone.
        sb.push_back(mk_res(32'd0, EXP_TS, 1'b1, 1'b1, 1'b0, 1'b1));
        stray_req++;
        repeat (3) @(negedge clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (obs(1) !== e) $display("FAIL rdv_stray_idle: got %h want %h", obs(1), e);
        else n_pass++;
    endtask

    task automatic test_timeout();
        res_t e;
        stuck1 = 1;
        sb.push_back(mk_res(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        run_probe(1, 100);
        e = sb.pop_front();
        n_checks++;
        if (r_got !== 1'b1 || r_lat != TMO1 + 2)
            $display("FAIL tmo_latency: got done=%0b at %0d want 1 at %0d", r_got, r_lat, TMO1 + 2);
        else n_pass++;
        n_checks++;
        if (obs(1) !== e) $display("FAIL tmo_results: got %h want %h", obs(1), e);
        else n_pass++;
        n_checks++;
        if (r_rd_done !== 1'b0) $display("FAIL tmo_read_low: got %0b want 0", r_rd_done);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({done1, bus1.avm_read} !== 2'b00) $display("FAIL tmo_done_pulse: got %b want 00", {done1, bus1.avm_read});
        else n_pass++;
        stuck1 = 0;
        sb.push_back(mk_res(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        stray_req++;
        repeat (3) @(negedge clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (obs(1) !== e) $display("FAIL tmo_stray: got %h want %h", obs(1), e);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        res_t e;
        bit   found;
        ws1 = 0; stuck1 = 0; rdv_lat = 2; id_w1 = 32'd0; ts_w1 = EXP_TS;
        found = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk); #1;
            if (n == 1) start1 = 1'b0;
            if (bus1.avm_read && !bus1.avm_waitrequest && bus1.avm_address === BASE1 + 32'h4) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (found !== 1'b1) $display("FAIL rmid_ts_accept: got %0b want 1", found);
        else n_pass++;
        @(negedge clk);
        rst_n1 = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (all_outs(1) !== 103'd0) $display("FAIL rmid_zero: got %h want 0", all_outs(1));
        else n_pass++;
        rst_n1 = 1'b1;
        repeat (5) @(negedge clk);
        sb.push_back(mk_res(32'd0, EXP_TS, 1'b1, 1'b1, 1'b0, 1'b1));
        run_probe(1, 80);
        e = sb.pop_front();
        n_checks++;
        if (r_got !== 1'b1) $display("FAIL rmid_redo_done: got %0b want 1", r_got);
        else n_pass++;
        n_checks++;
        if (obs(1) !== e) $display("FAIL rmid_redo_results: got %h want %h", obs(1), e);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n0 = 1'b0; rst_n1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
        ws0 = 0; ws1 = 0; rdv_lat = 2; stuck0 = 0; stuck1 = 0;
        id_w0 = 32'd0; ts_w0 = EXP_TS; id_w1 = 32'd0; ts_w1 = EXP_TS;
        stray_req = 0;
        test_reset();
        test_zero_wait();
        test_bad_id();
        test_waitrequest();
        test_rdv();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
